// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and small flag helpers for the sequenced ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_INC = 4'h2;
    localparam logic [3:0] ALU_DEC = 4'h3;
    localparam logic [3:0] ALU_AND = 4'h4;
    localparam logic [3:0] ALU_XOR = 4'h5;
    localparam logic [3:0] ALU_OR  = 4'h6;
    localparam logic [3:0] ALU_NOP = 4'h7;
    localparam logic [3:0] ALU_ADC = 4'h8;
    localparam logic [3:0] ALU_SBB = 4'h9;
    localparam logic [3:0] ALU_SHL = 4'hA;
    localparam logic [3:0] ALU_SHR = 4'hB;
    localparam logic [3:0] ALU_MUL = 4'hC;
    localparam logic [3:0] ALU_DIV = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

    // Signed overflow from sign bits only; carry/borrow-in does not change the rule.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative one-bit-per-cycle engine: shift-add multiply and restoring divide.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         div_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         done_o,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  hi_q, lo_q, m_q;
    logic          div_q, active_q;
    logic [CW-1:0] cnt_q;
    logic [N:0]    mul_sum_s, div_sh_s, div_diff_s;
    logic [N-1:0]  hi_nx_s, lo_nx_s;

    assign mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});
    assign div_sh_s   = {hi_q, lo_q[N-1]};
    assign div_diff_s = div_sh_s - {1'b0, m_q};

    // One iteration step; outputs expose the post-step value so the final step lands directly in the result.
    always_comb begin
        if (div_q) begin
            if (!div_diff_s[N]) begin
                hi_nx_s = div_diff_s[N-1:0];
                lo_nx_s = {lo_q[N-2:0], 1'b1};
            end else begin
                hi_nx_s = div_sh_s[N-1:0];
                lo_nx_s = {lo_q[N-2:0], 1'b0};
            end
        end else begin
            hi_nx_s = mul_sum_s[N:1];
            lo_nx_s = {mul_sum_s[0], lo_q[N-1:1]};
        end
    end

    assign done_o = active_q && (cnt_q == CW'(1));
    assign hi_o   = hi_nx_s;
    assign lo_o   = lo_nx_s;

    // Operand load on start, then N iteration steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            div_q    <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (start_i) begin
            hi_q     <= '0;
            lo_q     <= div_i ? a_i : b_i;
            m_q      <= div_i ? b_i : a_i;
            div_q    <= div_i;
            active_q <= 1'b1;
            cnt_q    <= CW'(N);
        end else if (active_q) begin
            hi_q     <= hi_nx_s;
            lo_q     <= lo_nx_s;
            cnt_q    <= cnt_q - CW'(1);
            active_q <= (cnt_q != CW'(1));
        end else begin
            cnt_q    <= cnt_q;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// N-bit ALU behind a valid/ready handshake; single-cycle ops and flags here, MUL/DIV in the iterative engine.
module alu_seq
    import alu_pkg::*;
#(
    parameter int N      = 8,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [3:0]   alu_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         carry_flag,
    output logic         zero_flag,
    output logic         neg_flag,
    output logic         ovf_flag
);
    alu_state_e   state_q, state_d;
    logic [N-1:0] result_q, result_d, result_hi_q, result_hi_d;
    logic         c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
    logic         op_div_q;
    logic         accept_s, mc_op_s, start_mc_s, mc_done_s, zn_upd_s;
    logic [N-1:0] eng_hi_s, eng_lo_s;
    logic [N:0]   sum_s, diff_s, inc_s, dec_s;

    // Divide by zero is handled as a one-cycle op, so it never starts the engine.
    assign mc_op_s    = is_multicycle(alu_op) &&
                        ((alu_op == ALU_MUL) ? MUL_EN : (DIV_EN && (b_in != '0)));
    assign accept_s   = in_valid && in_ready;
    assign start_mc_s = accept_s && mc_op_s;

    assign sum_s  = {1'b0, a_in} + {1'b0, b_in} + {{N{1'b0}}, (alu_op == ALU_ADC) & c_q};
    assign diff_s = {1'b0, a_in} - {1'b0, b_in} - {{N{1'b0}}, (alu_op == ALU_SBB) & c_q};
    assign inc_s  = {1'b0, a_in} + {{N{1'b0}}, 1'b1};
    assign dec_s  = {1'b0, a_in} - {{N{1'b0}}, 1'b1};

    alu_iter_muldiv #(.N(N)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_mc_s),
        .div_i   (alu_op == ALU_DIV),
        .a_i     (a_in),
        .b_i     (b_in),
        .done_o  (mc_done_s),
        .hi_o    (eng_hi_s),
        .lo_o    (eng_lo_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE with out_ready can accept the next op in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = mc_op_s ? ST_BUSY : ST_DONE;
                else          state_d = ST_IDLE;
            end
            ST_BUSY: begin
                if (mc_done_s) state_d = ST_DONE;
                else           state_d = ST_BUSY;
            end
            ST_DONE: begin
                if (accept_s)       state_d = mc_op_s ? ST_BUSY : ST_DONE;
                else if (out_ready) state_d = ST_IDLE;
                else                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        case (state_q)
            ST_IDLE: begin in_ready = 1'b1;      out_valid = 1'b0; end
            ST_DONE: begin in_ready = out_ready; out_valid = 1'b1; end
            default: begin in_ready = 1'b0;      out_valid = 1'b0; end
        endcase
    end

    // Result and flags change only on entry to DONE; NOP and disabled ops keep all four flags.
    always_comb begin
        result_d    = result_q;
        result_hi_d = result_hi_q;
        c_d         = c_q;
        z_d         = z_q;
        n_d         = n_q;
        v_d         = v_q;
        zn_upd_s    = 1'b0;
        if (accept_s && !mc_op_s) begin
            result_hi_d = '0;
            zn_upd_s    = 1'b1;
            case (alu_op)
                ALU_ADD, ALU_ADC: begin
                    result_d = sum_s[N-1:0]; c_d = sum_s[N];
                    v_d = add_ovf(a_in[N-1], b_in[N-1], sum_s[N-1]);
                end
                ALU_SUB, ALU_SBB: begin
                    result_d = diff_s[N-1:0]; c_d = diff_s[N];
                    v_d = sub_ovf(a_in[N-1], b_in[N-1], diff_s[N-1]);
                end
                ALU_INC: begin
                    result_d = inc_s[N-1:0]; c_d = inc_s[N];
                    v_d = add_ovf(a_in[N-1], 1'b0, inc_s[N-1]);
                end
                ALU_DEC: begin
                    result_d = dec_s[N-1:0]; c_d = dec_s[N];
                    v_d = sub_ovf(a_in[N-1], 1'b0, dec_s[N-1]);
                end
                ALU_AND: begin result_d = a_in & b_in; c_d = 1'b0; v_d = 1'b0; end
                ALU_XOR: begin result_d = a_in ^ b_in; c_d = 1'b0; v_d = 1'b0; end
                ALU_OR:  begin result_d = a_in | b_in; c_d = 1'b0; v_d = 1'b0; end
                ALU_SHL: begin
                    result_d = {a_in[N-2:0], 1'b0}; c_d = a_in[N-1];
                    v_d = a_in[N-1] ^ a_in[N-2];
                end
                ALU_SHR: begin result_d = {1'b0, a_in[N-1:1]}; c_d = a_in[0]; v_d = 1'b0; end
                ALU_DIV: begin
                    if (DIV_EN) begin
                        result_d = '1; result_hi_d = a_in; c_d = 1'b0; v_d = 1'b1;
                    end else begin
                        result_d = a_in; zn_upd_s = 1'b0;
                    end
                end
                default: begin result_d = a_in; zn_upd_s = 1'b0; end
            endcase
            if (zn_upd_s) begin
                z_d = (result_d == '0);
                n_d = result_d[N-1];
            end else begin
                z_d = z_q;
                n_d = n_q;
            end
        end else if ((state_q == ST_BUSY) && mc_done_s) begin
            result_d    = eng_lo_s;
            result_hi_d = eng_hi_s;
            c_d         = op_div_q ? 1'b0 : (eng_hi_s != '0);
            v_d         = op_div_q ? 1'b0 : (eng_hi_s != '0);
            z_d         = (eng_lo_s == '0);
            n_d         = eng_lo_s[N-1];
        end else begin
            result_d    = result_q;
        end
    end

    // Result/flag registers and captured MUL/DIV selector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q    <= '0;
            result_hi_q <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            v_q         <= 1'b0;
            op_div_q    <= 1'b0;
        end else begin
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            c_q         <= c_d;
            z_q         <= z_d;
            n_q         <= n_d;
            v_q         <= v_d;
            op_div_q    <= start_mc_s ? (alu_op == ALU_DIV) : op_div_q;
        end
    end

    assign result     = result_q;
    assign result_hi  = result_hi_q;
    assign carry_flag = c_q;
    assign zero_flag  = z_q;
    assign neg_flag   = n_q;
    assign ovf_flag   = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (N=8) against an integer-arithmetic reference model.
module tb_alu_seq;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0] a_in, b_in, result, result_hi;
    logic [3:0]   alu_op;
    logic         carry_flag, zero_flag, neg_flag, ovf_flag;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_c, m_z, m_n, m_v;
    int e_res, e_hi, e_lat;

    always #5 clk = ~clk;

    alu_seq #(.N(N), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .result_hi(result_hi),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .neg_flag(neg_flag),
        .ovf_flag(ovf_flag)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int sx(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    function automatic int ovr(input int s);
        return (s > 127 || s < -128) ? 1 : 0;
    endfunction

    // Reference model: signed/unsigned integer arithmetic, flags kept as model state.
    task automatic model_op(input int op, input int a, input int b);
        int s;
        bit upd;
        e_hi = 0; e_lat = 1; upd = 1'b1;
        case (op)
            0:  begin s = a + b; e_res = s % 256; m_v = ovr(sx(a) + sx(b)); m_c = s / 256; end
            1:  begin s = a - b; e_res = (s + 256) % 256; m_v = ovr(sx(a) - sx(b)); m_c = (a < b); end
            2:  begin s = a + 1; e_res = s % 256; m_v = ovr(sx(a) + 1); m_c = s / 256; end
            3:  begin e_res = (a + 255) % 256; m_v = ovr(sx(a) - 1); m_c = (a == 0); end
            4:  begin e_res = a & b; m_c = 0; m_v = 0; end
            5:  begin e_res = a ^ b; m_c = 0; m_v = 0; end
            6:  begin e_res = a | b; m_c = 0; m_v = 0; end
            8:  begin s = a + b + m_c; e_res = s % 256; m_v = ovr(sx(a) + sx(b) + m_c); m_c = s / 256; end
            9:  begin s = a - b - m_c; e_res = (s + 512) % 256; m_v = ovr(sx(a) - sx(b) - m_c); m_c = (s < 0); end
            10: begin e_res = (a * 2) % 256; m_c = a / 128; m_v = ovr(sx(a) * 2); end
            11: begin e_res = a / 2; m_c = a % 2; m_v = 0; end
            12: begin s = a * b; e_res = s % 256; e_hi = s / 256; m_c = (e_hi != 0); m_v = m_c; e_lat = N + 1; end
            13: begin
                if (b == 0) begin e_res = 255; e_hi = a; m_c = 0; m_v = 1; end
                else begin e_res = a / b; e_hi = a % b; m_c = 0; m_v = 0; e_lat = N + 1; end
            end
            default: begin e_res = a; upd = 1'b0; end
        endcase
        if (upd) begin
            m_z = (e_res == 0);
            m_n = (e_res >= 128);
        end
    endtask

    // Issue one op at a negedge, measure latency, check outputs, then consume the result.
    task automatic run_op(input int op, input int a, input int b, input string tag);
        int lat;
        bit acc, busy_bad;
        model_op(op, a, b);
        in_valid = 1'b1; alu_op = 4'(op); a_in = 8'(a); b_in = 8'(b); out_ready = 1'b0;
        acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (in_ready) begin acc = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!acc) begin
            n_fail++;
            $display("FAIL %s accept: in_ready got %b want 1", tag, in_ready);
            in_valid = 1'b0;
        end else begin
            lat = 0; busy_bad = 1'b0;
            do begin
                @(negedge clk);
                lat++;
                if (!out_valid && in_ready) busy_bad = 1'b1;
                in_valid = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); alu_op = 4'($urandom);
            end while (!out_valid && lat < 40);
            n_cmp++;
            if (lat != e_lat) begin
                n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, lat, e_lat);
            end
            if (e_lat > 1) begin
                n_cmp++;
                if (busy_bad) begin n_fail++; $display("FAIL %s busy_ready: got 1 want 0", tag); end
            end
            n_cmp++;
            if (result !== 8'(e_res)) begin
                n_fail++; $display("FAIL %s result: got %h want %h", tag, result, 8'(e_res));
            end
            n_cmp++;
            if (result_hi !== 8'(e_hi)) begin
                n_fail++; $display("FAIL %s result_hi: got %h want %h", tag, result_hi, 8'(e_hi));
            end
            n_cmp++;
            if ({carry_flag, zero_flag, neg_flag, ovf_flag} !== {1'(m_c), 1'(m_z), 1'(m_n), 1'(m_v)}) begin
                n_fail++;
                $display("FAIL %s flags CZNV: got %b want %b", tag,
                         {carry_flag, zero_flag, neg_flag, ovf_flag}, {1'(m_c), 1'(m_z), 1'(m_n), 1'(m_v)});
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = 4'h0; a_in = 8'h00; b_in = 8'h00;
        m_c = 0; m_z = 0; m_n = 0; m_v = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if ({result, result_hi} !== 16'h0000) begin
            n_fail++; $display("FAIL reset result: got %h/%h want 00/00", result, result_hi);
        end
        n_cmp++;
        if ({carry_flag, zero_flag, neg_flag, ovf_flag} !== 4'b0000) begin
            n_fail++; $display("FAIL reset flags: got %b want 0000", {carry_flag, zero_flag, neg_flag, ovf_flag});
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(0,  'hFF, 'h01, "add_wrap");
        run_op(8,  'h00, 'h00, "adc_carry");
        run_op(0,  'h7F, 'h01, "add_ovf");
        run_op(1,  'h05, 'h07, "sub_borrow");
        run_op(12, 'h10, 'h20, "mul_hi");
        run_op(13, 'h64, 'h07, "div");
        run_op(13, 'h5A, 'h00, "div_zero");
        run_op(2,  'hFF, 'h00, "inc_wrap");
        run_op(3,  'h80, 'h00, "dec_ovf");
        run_op(9,  'h00, 'h00, "sbb_borrow");
        run_op(10, 'h40, 'h00, "shl_ovf");
        run_op(11, 'h01, 'h00, "shr_c");
        run_op(12, 'hFF, 'hFF, "mul_max");
        run_op(15, 'h12, 'h34, "op_f_nop");
    endtask

    task automatic test_backpressure();
        model_op(5, 'hF0, 'hF0);
        in_valid = 1'b1; alu_op = 4'h5; a_in = 8'hF0; b_in = 8'hF0; out_ready = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp accept: in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; a_in = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({out_valid, in_ready, zero_flag} !== 3'b101 || result !== 8'(e_res)) begin
                n_fail++;
                $display("FAIL bp hold%0d: got v/r/z=%b%b%b res=%h want 101 res=%h",
                         k, out_valid, in_ready, zero_flag, result, 8'(e_res));
            end
            @(negedge clk);
        end
        model_op(7, 'h3C, 'h00);
        in_valid = 1'b1; alu_op = 4'h7; a_in = 8'h3C; b_in = 8'h00; out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp b2b in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || result !== 8'(e_res) || result_hi !== 8'h00) begin
            n_fail++;
            $display("FAIL bp nop: got v=%b res=%h hi=%h want 1 %h 00", out_valid, result, result_hi, 8'(e_res));
        end
        n_cmp++;
        if ({carry_flag, zero_flag, neg_flag, ovf_flag} !== {1'(m_c), 1'(m_z), 1'(m_n), 1'(m_v)}) begin
            n_fail++;
            $display("FAIL bp nop flags: got %b want %b",
                     {carry_flag, zero_flag, neg_flag, ovf_flag}, {1'(m_c), 1'(m_z), 1'(m_n), 1'(m_v)});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int op, a, b;
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 15));
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            run_op(op, a, b, $sformatf("rand%0d_op%0h", i, op));
        end
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        run_op(0, 'h80, 'h90, "pre_add");
        in_valid = 1'b1; alu_op = 4'hC; a_in = 8'hFF; b_in = 8'hFF; out_ready = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mul accept: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        m_c = 0; m_z = 0; m_n = 0; m_v = 0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || {result, result_hi} !== 16'h0000 ||
            {carry_flag, zero_flag, neg_flag, ovf_flag} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mul clear: got v=%b res=%h hi=%h f=%b want 0 00 00 0000",
                     out_valid, result, result_hi, {carry_flag, zero_flag, neg_flag, ovf_flag});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mul in_ready: got %b want 1", in_ready); end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_fail++; $display("FAIL rst_mul stale_valid: got 1 want 0"); end
        run_op(8, 'h01, 'h01, "post_rst_adc");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
